// File: rtl/sparse_mac_array_if.sv
// rtl/sparse_mac_array_if.sv - tile-in / result-out handshake bundle for sparse_mac_array
interface sparse_mac_array_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4
);
  localparam int IN_SIZE  = N_ROWS * N_COLS;
  localparam int IDX_BITS = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int ENT_W    = 2 * IDX_BITS + 1;
  localparam int NNZ_W    = $clog2(IN_SIZE + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [IN_SIZE*DATA_W-1:0]   y_in;
  logic [IN_SIZE*DATA_W-1:0]   h_in;
  logic [IN_SIZE*ENT_W-1:0]    s_in;
  logic [NNZ_W-1:0]            nnz_in;
  logic                        last_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [IN_SIZE*ACC_W-1:0]    u_out;
  logic                        busy;

  modport master (
    output in_valid, y_in, h_in, s_in, nnz_in, last_in, out_ready,
    input  in_ready, out_valid, u_out, busy
  );

  modport slave (
    input  in_valid, y_in, h_in, s_in, nnz_in, last_in, out_ready,
    output in_ready, out_valid, u_out, busy
  );
endinterface

// File: rtl/sparse_mac_array.sv
// rtl/sparse_mac_array.sv - sparse multiply-accumulate over a transform tile, LANES entries per cycle
module sparse_mac_array #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int LANES  = 2,
  parameter int SAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sparse_mac_array_if.slave bus
);
  localparam int IN_SIZE  = N_ROWS * N_COLS;
  localparam int IDX_BITS = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int ENT_W    = 2 * IDX_BITS + 1;
  localparam int NNZ_W    = $clog2(IN_SIZE + 1);
  localparam int PROD_W   = 2 * DATA_W;
  // Wide enough for psum plus every lane product of one cycle without overflow.
  localparam int SUM_W    = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + $clog2(LANES + 1) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

  state_t                     state;
  logic [IN_SIZE*DATA_W-1:0]  y_r;
  logic [IN_SIZE*DATA_W-1:0]  h_r;
  logic [IN_SIZE*ENT_W-1:0]   s_r;
  logic                       last_r;
  logic [NNZ_W-1:0]           nnz_r;
  logic [NNZ_W-1:0]           g;
  logic signed [ACC_W-1:0]    psum [IN_SIZE];

  logic signed [DATA_W-1:0]   y_a [IN_SIZE];
  logic signed [DATA_W-1:0]   h_a [IN_SIZE];
  logic [ENT_W-1:0]           s_a [IN_SIZE];

  logic                       lane_hit  [LANES];
  logic [IDX_BITS-1:0]        lane_dst  [LANES];
  logic signed [PROD_W-1:0]   lane_prod [LANES];

  logic signed [SUM_W-1:0]    lane_sum [IN_SIZE];
  logic signed [SUM_W-1:0]    acc_wide [IN_SIZE];
  logic signed [ACC_W-1:0]    psum_nxt [IN_SIZE];

  logic                       last_grp;
  logic [NNZ_W-1:0]           nnz_clamp;

  for (genvar i = 0; i < IN_SIZE; i++) begin : g_unpack
    assign y_a[i] = y_r[i*DATA_W +: DATA_W];
    assign h_a[i] = h_r[i*DATA_W +: DATA_W];
    assign s_a[i] = s_r[i*ENT_W +: ENT_W];
    assign bus.u_out[i*ACC_W +: ACC_W] = psum[i];
  end

  // Each lane decodes one list entry of the current group; out-of-list or
  // out-of-tile entries simply never hit.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int                  k;
    logic                in_list;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] src;
    logic [IDX_BITS-1:0] dst;
    logic [IDX_BITS-1:0] src_safe;
    logic                en;

    assign k        = int'(g) * LANES + l;
    assign in_list  = (k < IN_SIZE) && (k < int'(nnz_r));
    assign idx      = in_list ? IDX_BITS'(k) : '0;
    assign en       = s_a[idx][ENT_W-1];
    assign dst      = s_a[idx][IDX_BITS +: IDX_BITS];
    assign src      = s_a[idx][IDX_BITS-1:0];
    assign lane_hit[l] = in_list && en && (h_a[idx] != '0) &&
                         (int'(src) < IN_SIZE) && (int'(dst) < IN_SIZE);
    assign src_safe = lane_hit[l] ? src : '0;
    assign lane_dst[l]  = dst;
    assign lane_prod[l] = PROD_W'(y_a[src_safe]) * PROD_W'(h_a[idx]);
  end

  // Sum every lane landing on the same element, then apply one clamp/wrap per element.
  always_comb begin
    for (int d = 0; d < IN_SIZE; d++) begin
      lane_sum[d] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (lane_hit[l] && (lane_dst[l] == IDX_BITS'(d))) begin
          lane_sum[d] = lane_sum[d] + SUM_W'(lane_prod[l]);
        end
      end
      acc_wide[d] = SUM_W'(psum[d]) + lane_sum[d];
      if ((SAT != 0) && (acc_wide[d] > ACC_MAX)) begin
        psum_nxt[d] = ACC_W'(ACC_MAX);
      end else if ((SAT != 0) && (acc_wide[d] < ACC_MIN)) begin
        psum_nxt[d] = ACC_W'(ACC_MIN);
      end else begin
        psum_nxt[d] = ACC_W'(acc_wide[d]);
      end
    end
  end

  assign last_grp  = (nnz_r == '0) || (int'(g) == (int'(nnz_r) - 1) / LANES);
  assign nnz_clamp = (int'(bus.nnz_in) > IN_SIZE) ? NNZ_W'(IN_SIZE) : bus.nnz_in;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state != IDLE);

  // Control FSM plus tile capture and accumulator update; psum survives
  // non-final tiles and is cleared only when a result is taken or on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      y_r    <= '0;
      h_r    <= '0;
      s_r    <= '0;
      last_r <= 1'b0;
      nnz_r  <= '0;
      g      <= '0;
      for (int i = 0; i < IN_SIZE; i++) psum[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            y_r    <= bus.y_in;
            h_r    <= bus.h_in;
            s_r    <= bus.s_in;
            last_r <= bus.last_in;
            nnz_r  <= nnz_clamp;
            g      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < IN_SIZE; i++) psum[i] <= psum_nxt[i];
          if (last_grp) begin
            state <= last_r ? OUT : IDLE;
          end else begin
            g <= g + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            for (int i = 0; i < IN_SIZE; i++) psum[i] <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse_mac_array.sv
// tb/tb_sparse_mac_array.sv - directed and random tiles into saturating and wrapping sparse_mac_array instances
module tb_sparse_mac_array;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int N_ROWS  = 4;
  localparam int N_COLS  = 4;
  localparam int LANES   = 2;
  localparam int IN_SIZE = 16;
  localparam int ENT_W   = 9;
  localparam int NNZ_W   = 5;
  localparam int VEC_W   = IN_SIZE * ACC_W;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sparse_mac_array_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS)) bus_s ();
  sparse_mac_array_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS)) bus_w ();

  sparse_mac_array #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                     .LANES(LANES), .SAT(1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  sparse_mac_array #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                     .LANES(LANES), .SAT(0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  logic signed [DATA_W-1:0] ty [IN_SIZE];
  logic signed [DATA_W-1:0] th [IN_SIZE];
  logic                     ten [IN_SIZE];
  logic [3:0]               tdst [IN_SIZE];
  logic [3:0]               tsrc [IN_SIZE];
  int                       tnnz;
  logic                     tlast;
  longint                   ms [IN_SIZE];
  longint                   mw [IN_SIZE];
  logic [VEC_W-1:0]         q_s [$];
  logic [VEC_W-1:0]         q_w [$];

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tile();
    for (int i = 0; i < IN_SIZE; i++) begin
      ty[i] = '0; th[i] = '0; ten[i] = 1'b0; tdst[i] = '0; tsrc[i] = '0;
    end
    tnnz = 0;
    tlast = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < IN_SIZE; i++) begin
      ms[i] = 0; mw[i] = 0;
    end
    q_s.delete();
    q_w.delete();
  endtask

  task automatic drive(input logic v);
    logic [IN_SIZE*DATA_W-1:0] y, h;
    logic [IN_SIZE*ENT_W-1:0]  s;
    for (int i = 0; i < IN_SIZE; i++) begin
      y[i*DATA_W +: DATA_W] = ty[i];
      h[i*DATA_W +: DATA_W] = th[i];
      s[i*ENT_W +: ENT_W]   = {ten[i], tdst[i], tsrc[i]};
    end
    bus_s.in_valid = v; bus_s.y_in = y; bus_s.h_in = h; bus_s.s_in = s;
    bus_s.nnz_in = NNZ_W'(tnnz); bus_s.last_in = tlast;
    bus_w.in_valid = v; bus_w.y_in = y; bus_w.h_in = h; bus_w.s_in = s;
    bus_w.nnz_in = NNZ_W'(tnnz); bus_w.last_in = tlast;
  endtask

  task automatic drive_junk();
    bus_s.in_valid = 1'b0; bus_w.in_valid = 1'b0;
    bus_s.y_in = ~bus_s.y_in; bus_s.h_in = ~bus_s.h_in; bus_s.s_in = ~bus_s.s_in;
    bus_s.nnz_in = ~bus_s.nnz_in; bus_s.last_in = ~bus_s.last_in;
    bus_w.y_in = bus_s.y_in; bus_w.h_in = bus_s.h_in; bus_w.s_in = bus_s.s_in;
    bus_w.nnz_in = bus_s.nnz_in; bus_w.last_in = bus_s.last_in;
  endtask

  task automatic model_tile();
    int nn, ng, k;
    longint add [IN_SIZE];
    longint s;
    logic [VEC_W-1:0] vs, vw;
    nn = (tnnz > IN_SIZE) ? IN_SIZE : tnnz;
    ng = (nn == 0) ? 1 : (nn + LANES - 1) / LANES;
    for (int gi = 0; gi < ng; gi++) begin
      for (int d = 0; d < IN_SIZE; d++) add[d] = 0;
      for (int l = 0; l < LANES; l++) begin
        k = gi * LANES + l;
        if (k < nn && ten[k] && th[k] != 0)
          add[tdst[k]] += longint'(ty[tsrc[k]]) * longint'(th[k]);
      end
      for (int d = 0; d < IN_SIZE; d++) begin
        s = ms[d] + add[d];
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        ms[d] = s;
        mw[d] = longint'(int'(mw[d] + add[d]));
      end
    end
    if (tlast) begin
      for (int d = 0; d < IN_SIZE; d++) begin
        vs[d*ACC_W +: ACC_W] = ms[d][31:0];
        vw[d*ACC_W +: ACC_W] = mw[d][31:0];
        ms[d] = 0;
        mw[d] = 0;
      end
      q_s.push_back(vs);
      q_w.push_back(vw);
    end
  endtask

  task automatic send_tile();
    int n = 0;
    while (!bus_s.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 1'b0, 1'b1);
    drive(1'b1);
    model_tile();
    @(negedge clk);
    drive_junk();
  endtask

  task automatic wait_out(input int exp_lat);
    int k = 0;
    while (!bus_s.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      chk("out_timeout", 1'b0, 1'b1);
    end else begin
      if (exp_lat >= 0) chk("latency", k, exp_lat);
      chk("wrap_out_valid", bus_w.out_valid, 1'b1);
      if (q_s.size() == 0) begin
        chk("scoreboard_empty", 1'b0, 1'b1);
      end else begin
        chk("u_out_sat", bus_s.u_out, q_s.pop_front());
        chk("u_out_wrap", bus_w.u_out, q_w.pop_front());
      end
    end
  endtask

  task automatic release_out();
    bus_s.out_ready = 1'b1; bus_w.out_ready = 1'b1;
    @(negedge clk);
    bus_s.out_ready = 1'b0; bus_w.out_ready = 1'b0;
    chk("in_ready_after_out", bus_s.in_ready, 1'b1);
    chk("out_valid_cleared", bus_s.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VEC_W-1:0] v;
    int nn, gcnt;
    logic bad;

    clear_tile();
    clear_model();
    drive(1'b0);
    bus_s.out_ready = 1'b0; bus_w.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", bus_s.in_ready, 1'b1);
    chk("reset_out_valid", bus_s.out_valid, 1'b0);
    chk("reset_busy", bus_s.busy, 1'b0);
    chk("reset_u_out", bus_s.u_out, '0);

    // dense tile: out_valid 8 cycles after accept, u[i] = 2*(i+1)
    clear_tile();
    for (int i = 0; i < IN_SIZE; i++) begin
      ty[i] = DATA_W'(i + 1); th[i] = 16'sd2; ten[i] = 1'b1; tdst[i] = 4'(i); tsrc[i] = 4'(i);
    end
    tnnz = 16; tlast = 1'b1;
    send_tile();
    chk("run_busy", bus_s.busy, 1'b1);
    chk("run_in_ready", bus_s.in_ready, 1'b0);
    wait_out(8);
    chk("dense_u5", bus_s.u_out[5*ACC_W +: ACC_W], 32'd12);
    release_out();

    // two channel tiles accumulate into one result
    clear_tile();
    for (int i = 0; i < IN_SIZE; i++) ty[i] = 16'sd1;
    th[0] = 16'sd3; ten[0] = 1'b1; tdst[0] = 4'd5; tsrc[0] = 4'd0; tnnz = 1; tlast = 1'b0;
    send_tile();
    @(negedge clk);
    chk("nonlast_idle", bus_s.in_ready, 1'b1);
    chk("nonlast_no_out", bus_s.out_valid, 1'b0);
    tlast = 1'b1;
    send_tile();
    wait_out(1);
    chk("two_tile_u5", bus_s.u_out[5*ACC_W +: ACC_W], 32'd6);
    release_out();

    // lane conflict: both lanes target element 3
    clear_tile();
    ty[0] = 16'sd4; ty[1] = 16'sd5; th[0] = 16'sd10; th[1] = -16'sd1;
    ten[0] = 1'b1; ten[1] = 1'b1; tdst[0] = 4'd3; tdst[1] = 4'd3; tsrc[0] = 4'd0; tsrc[1] = 4'd1;
    tnnz = 2; tlast = 1'b1;
    send_tile();
    wait_out(1);
    chk("conflict_u3", bus_s.u_out[3*ACC_W +: ACC_W], 32'd35);
    release_out();

    // saturation vs wrap over three full tiles into element 0
    clear_tile();
    ty[0] = 16'sd32767;
    for (int i = 0; i < IN_SIZE; i++) begin
      th[i] = 16'sd32767; ten[i] = 1'b1;
    end
    tnnz = 16; tlast = 1'b0;
    send_tile();
    send_tile();
    tlast = 1'b1;
    send_tile();
    wait_out(8);
    chk("sat_u0", bus_s.u_out[0 +: ACC_W], 32'h7FFFFFFF);
    chk("wrap_u0", bus_w.u_out[0 +: ACC_W], 32'hFFD00030);
    release_out();

    // backpressure: result held, new tiles ignored while in OUT
    clear_tile();
    ty[2] = 16'sd7; th[0] = -16'sd3; ten[0] = 1'b1; tdst[0] = 4'd9; tsrc[0] = 4'd2;
    tnnz = 1; tlast = 1'b1;
    send_tile();
    wait_out(1);
    v = '0;
    v[9*ACC_W +: ACC_W] = 32'hFFFFFFEB;
    for (int c = 0; c < 5; c++) begin
      chk("hold_u_out", bus_s.u_out, v);
      chk("hold_in_ready", bus_s.in_ready, 1'b0);
      chk("hold_out_valid", bus_s.out_valid, 1'b1);
      drive(1'b1);
      @(negedge clk);
    end
    drive(1'b0);
    release_out();
    // nnz=0 tile right after: result must be all zero
    clear_tile();
    ten[0] = 1'b1; th[0] = 16'sd5; ty[0] = 16'sd5; tnnz = 0; tlast = 1'b1;
    send_tile();
    wait_out(1);
    release_out();

    // nnz=0 final tile keeps earlier accumulation; nnz_in above tile size clamps
    clear_tile();
    ty[1] = 16'sd100; th[0] = 16'sd5; ten[0] = 1'b1; tdst[0] = 4'd4; tsrc[0] = 4'd1;
    tnnz = 1; tlast = 1'b0;
    send_tile();
    tnnz = 0; tlast = 1'b1; ten[1] = 1'b1; th[1] = 16'sd9; tdst[1] = 4'd4;
    send_tile();
    wait_out(1);
    chk("nnz0_u4", bus_s.u_out[4*ACC_W +: ACC_W], 32'd500);
    release_out();
    clear_tile();
    for (int i = 0; i < IN_SIZE; i++) begin
      ty[i] = 16'sd1; th[i] = 16'sd1; ten[i] = (i % 3) != 0; tdst[i] = 4'(i % 4); tsrc[i] = 4'(i);
    end
    tnnz = 20; tlast = 1'b1;
    send_tile();
    wait_out(8);
    release_out();

    // reset in the middle of a final tile discards everything
    clear_tile();
    ty[0] = 16'sd9; th[0] = 16'sd9; ten[0] = 1'b1; tdst[0] = 4'd1; tnnz = 1; tlast = 1'b0;
    send_tile();
    clear_tile();
    for (int i = 0; i < IN_SIZE; i++) begin
      ty[i] = 16'sd3; th[i] = 16'sd3; ten[i] = 1'b1; tdst[i] = 4'(i); tsrc[i] = 4'(i);
    end
    tnnz = 16; tlast = 1'b1;
    send_tile();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus_s.busy, 1'b0);
    chk("rst_out_valid", bus_s.out_valid, 1'b0);
    chk("rst_u_out", bus_s.u_out, '0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_s.out_valid || bus_w.out_valid) bad = 1'b1;
    end
    chk("rst_no_out", bad, 1'b0);
    chk("rst_in_ready", bus_s.in_ready, 1'b1);
    clear_tile();
    ty[3] = 16'sd2; th[0] = 16'sd4; ten[0] = 1'b1; tdst[0] = 4'd6; tsrc[0] = 4'd3;
    tnnz = 1; tlast = 1'b1;
    send_tile();
    wait_out(1);
    chk("post_rst_u6", bus_s.u_out[6*ACC_W +: ACC_W], 32'd8);
    release_out();

    // random tiles
    for (int t = 0; t < 8; t++) begin
      clear_tile();
      for (int i = 0; i < IN_SIZE; i++) begin
        ty[i]   = DATA_W'($urandom);
        th[i]   = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
        ten[i]  = ($urandom_range(0, 3) != 0);
        tdst[i] = 4'($urandom_range(0, 15));
        tsrc[i] = 4'($urandom_range(0, 15));
      end
      tnnz  = $urandom_range(0, 20);
      tlast = (t == 7) ? 1'b1 : ($urandom_range(0, 2) == 0);
      nn    = (tnnz > IN_SIZE) ? IN_SIZE : tnnz;
      gcnt  = (nn == 0) ? 1 : (nn + LANES - 1) / LANES;
      send_tile();
      if (tlast) begin
        wait_out(gcnt);
        release_out();
      end
    end

    chk("scoreboard_drained", q_s.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
